// File: rtl/wave_pkg.sv
// Shared types and default geometry for the waveform capture block.
package wave_pkg;
    localparam int WAVE_ADDR_W = 12;
    localparam int WAVE_DATA_W = 8;
    localparam int WAVE_DEPTH  = 4096;
    // One extra bit so a full 2**ADDR_W capture can reach its terminal count
    localparam int DEPTH_CNT_W = WAVE_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } wave_state_e;
endpackage

// File: rtl/wave_trig_detect.sv
// Rising level-crossing detector: registered previous sample, combinational hit.
module wave_trig_detect #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    output logic              hit_o
);
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear_i) begin
            prev_valid_q <= 1'b0;
        end else if (en_i && valid_i) begin
            prev_q       <= sample_i;
            prev_valid_q <= 1'b1;
        end
    end

    // The first sample after arming only seeds prev and can never fire
    assign hit_o = en_i && valid_i && prev_valid_q &&
                   (prev_q < level_i) && (sample_i >= level_i);
endmodule

// File: rtl/wave_capture_ram.sv
// Arms on start, optionally waits for a rising trigger, then writes DEPTH samples to RAM.
module wave_capture_ram
    import wave_pkg::*;
#(
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DATA_W = WAVE_DATA_W,
    parameter int DEPTH  = WAVE_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              triggered,
    output logic              done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    wave_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trig_en_q, trig_en_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_d, done_d;
    logic              wren_q, busy_q, trig_q, done_q;
    logic              arm, hit;

    assign arm = (state_q == IDLE) && start && !abort;

    wave_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (arm),
        .en_i     ((state_q == ARMED) && trig_en_q),
        .valid_i  (sample_valid),
        .sample_i (sample),
        .level_i  (level_q),
        .hit_o    (hit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        trig_en_d = trig_en_q;
        level_d   = level_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    trig_en_d = trig_en;
                    level_d   = trig_level;
                    cnt_d     = '0;
                    state_d   = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid && (!trig_en_q || hit)) begin
                    addr_d  = '0;
                    data_d  = sample;
                    wren_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid) begin
                    addr_d = cnt_q[ADDR_W-1:0];
                    data_d = sample;
                    wren_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            trig_en_q <= 1'b0;
            level_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trig_en_q <= trig_en_d;
            level_q   <= level_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= (state_d != IDLE);
            trig_q    <= (state_d == CAPTURE);
            done_q    <= done_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign busy        = busy_q;
    assign triggered   = trig_q;
    assign done        = done_q;
endmodule
